// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch front end: default widths, PC step and
// the {pc, instr} entry carried from the instruction memory to decode.
package fetch_pkg;

  localparam int XLEN_DEF = 64;
  localparam int ILEN_DEF = 32;
  localparam int PC_STEP  = 4;
  localparam logic [XLEN_DEF-1:0] RESET_PC_DEF = '0;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [ILEN_DEF-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with push/pop/clear and occupancy.
// The head is read straight from registered storage, so a pushed entry is
// visible at dout_o one cycle after the push.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         clear_i,
  input  logic                         push_i,
  input  entry_t                       din_i,
  input  logic                         pop_i,
  output entry_t                       dout_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         empty_o,
  output logic                         full_o
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]   count_q;
  logic            do_push, do_pop;

  // Pop from empty is a no-op; push into a full queue is only taken when a
  // pop frees the head slot in the same cycle.
  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != FULL_CNT) || do_pop);

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);

  // Pointer and occupancy update; clear empties the queue in one cycle.
  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage; contents past the tail are don't-care.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: sequential PC generation, credit-limited requests to the
// instruction memory, in-order response queue towards decode, and branch
// flush that discards responses still in flight.
// Optional: FETCH_BYPASS_EN lets a response reach decode in its arrival
// cycle when the queue is empty.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int ILEN  = ILEN_DEF,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            branchtaken_i,
  input  logic [XLEN-1:0] branch_target_i,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [ILEN-1:0] imem_rsp_data_i,
  output logic            fd_valid_o,
  input  logic            fd_ready_i,
  output logic [ILEN-1:0] fd_instr_o,
  output logic [XLEN-1:0] fd_pc_o
);

  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } entry_t;

  logic [XLEN-1:0] pc_q, pc_d;
  // PC of the next response that will be kept. Responses return in order
  // and requests go out to consecutive PCs, so once the dropped responses
  // have drained this tracks the request stream exactly.
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   out_q, out_d, drop_q, drop_d, occ;
  logic [CW:0]     credit_sum;
  logic [XLEN-1:0] tgt_pc;
  logic            empty, full, req_fire, rsp_keep, push, pop, fd_v;
  entry_t          push_e, head, fd_e;
  logic            unused_tgt_lsb;

  assign unused_tgt_lsb = ^branch_target_i[1:0];
  assign tgt_pc         = {branch_target_i[XLEN-1:2], 2'b00};

  // Credit: never have more requests in flight than free queue slots.
  assign credit_sum       = {1'b0, occ} + {1'b0, out_q};
  assign imem_req_valid_o = !reset_i && !branchtaken_i && (credit_sum < (CW+1)'(DEPTH));
  assign imem_addr_o      = pc_q;
  assign req_fire         = imem_req_valid_o && imem_req_ready_i;

  assign rsp_keep = imem_rsp_valid_i && (drop_q == '0) && !branchtaken_i;
  assign push_e   = '{pc: rsp_pc_q, instr: imem_rsp_data_i};

`ifdef FETCH_BYPASS_EN
  logic byp;
  assign byp  = rsp_keep && empty;
  assign fd_v = !reset_i && !branchtaken_i && (!empty || byp);
  assign fd_e = empty ? push_e : head;
  // A bypassed response taken by decode this cycle never enters the queue.
  assign push = rsp_keep && !(byp && fd_ready_i);
`else
  assign fd_v = !reset_i && !branchtaken_i && !empty;
  assign fd_e = head;
  assign push = rsp_keep;
`endif

  assign pop        = fd_v && fd_ready_i && !empty;
  assign fd_valid_o = fd_v;
  assign fd_pc_o    = fd_v ? fd_e.pc    : '0;
  assign fd_instr_o = fd_v ? fd_e.instr : '0;

  fetch_fifo #(.DEPTH(DEPTH), .entry_t(entry_t)) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (branchtaken_i),
    .push_i  (push),
    .din_i   (push_e),
    .pop_i   (pop),
    .dout_o  (head),
    .count_o (occ),
    .empty_o (empty),
    .full_o  (full)
  );

  // Next PC, in-flight and drop counters; a branch turns everything still
  // in flight (minus this cycle's response) into responses to discard.
  always_comb begin
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    out_d    = out_q;
    drop_d   = drop_q;
    if (branchtaken_i) begin
      pc_d     = tgt_pc;
      rsp_pc_d = tgt_pc;
      out_d    = out_q - CW'(imem_rsp_valid_i);
      drop_d   = out_q - CW'(imem_rsp_valid_i);
    end else begin
      if (req_fire) pc_d = pc_q + XLEN'(PC_STEP);
      if (imem_rsp_valid_i && (drop_q == '0)) rsp_pc_d = rsp_pc_q + XLEN'(PC_STEP);
      if (imem_rsp_valid_i && (drop_q != '0)) drop_d = drop_q - 1'b1;
      out_d = out_q + CW'(req_fire) - CW'(imem_rsp_valid_i);
    end
  end

  // Front-end state registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      out_q    <= '0;
      drop_q   <= '0;
    end else begin
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
    end
  end

  // Credit invariant and no-overflow check.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (credit_sum <= (CW+1)'(DEPTH));
      assert (!(push && full && !pop));
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: in-order memory model with configurable latency,
// expected PC stream computed from reset/branch targets.
module tb_fetch_queue;

  localparam int XLEN  = 64;
  localparam int ILEN  = 32;
  localparam int DEPTH = 4;
  localparam logic [63:0] RESET_PC = 64'h0;
`ifdef FETCH_BYPASS_EN
  localparam int FIRST_LAT = 1;
`else
  localparam int FIRST_LAT = 2;
`endif

  logic            clk_i = 1'b0;
  logic            reset_i, branchtaken_i, imem_req_ready_i, imem_rsp_valid_i, fd_ready_i;
  logic [XLEN-1:0] branch_target_i, imem_addr_o, fd_pc_o;
  logic [ILEN-1:0] imem_rsp_data_i, fd_instr_o;
  logic            imem_req_valid_o, fd_valid_o;

  always #5 clk_i = ~clk_i;

  fetch_queue #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .branchtaken_i(branchtaken_i),
    .branch_target_i(branch_target_i), .imem_req_valid_o(imem_req_valid_o),
    .imem_req_ready_i(imem_req_ready_i), .imem_addr_o(imem_addr_o),
    .imem_rsp_valid_i(imem_rsp_valid_i), .imem_rsp_data_i(imem_rsp_data_i),
    .fd_valid_o(fd_valid_o), .fd_ready_i(fd_ready_i), .fd_instr_o(fd_instr_o),
    .fd_pc_o(fd_pc_o)
  );

  typedef struct { int due; logic [63:0] addr; } mreq_t;
  mreq_t       mq[$];
  logic [63:0] obs_req[$];
  logic [63:0] obs_pc[$];
  logic [31:0] obs_instr[$];
  int cyc = 0, last_due = -1, lat_lo = 1, lat_hi = 1;
  int n_chk = 0, n_fail = 0;
  logic        s_req_v, s_fdv;
  logic [63:0] s_addr, s_pc;
  logic [31:0] s_instr;

  // Instruction word stored at an address in the memory model.
  function automatic logic [31:0] f(input logic [63:0] a);
    return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h5A5A0F0F;
  endfunction

  // One clock cycle: drive inputs, sample outputs, record handshakes.
  task automatic step(input bit rst, input bit br, input logic [63:0] tgt,
                      input bit rdy, input bit fdr);
    mreq_t m;
    int due;
    reset_i = rst; branchtaken_i = br; branch_target_i = tgt;
    imem_req_ready_i = rdy; fd_ready_i = fdr;
    imem_rsp_valid_i = 1'b0; imem_rsp_data_i = $urandom;
    if (!rst && mq.size() > 0 && mq[0].due == cyc) begin
      m = mq.pop_front();
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = f(m.addr);
    end
    #1;
    s_req_v = imem_req_valid_o; s_addr = imem_addr_o;
    s_fdv = fd_valid_o; s_pc = fd_pc_o; s_instr = fd_instr_o;
    if (rst) begin
      mq.delete(); cyc = 0; last_due = -1;
    end else begin
      if (s_req_v && rdy) begin
        obs_req.push_back(s_addr);
        due = cyc + int'($urandom_range(lat_hi, lat_lo));
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        m.due = due; m.addr = s_addr;
        mq.push_back(m);
      end
      if (s_fdv && fdr) begin
        obs_pc.push_back(s_pc);
        obs_instr.push_back(s_instr);
      end
      cyc++;
    end
    @(posedge clk_i); #1;
  endtask

  task automatic do_reset(input int lo, input int hi);
    lat_lo = lo; lat_hi = hi;
    step(1, 0, 0, 1, 1);
    step(1, 0, 0, 1, 1);
    obs_req.delete(); obs_pc.delete(); obs_instr.delete();
  endtask

  task automatic test_reset();
    lat_lo = 1; lat_hi = 1;
    for (int i = 0; i < 2; i++) begin
      step(1, 1, 64'h5550, 1, 1);   // branch during reset: reset wins
      n_chk++; if (s_req_v !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid got %b want 0", s_req_v); end
      n_chk++; if (s_fdv !== 1'b0) begin n_fail++; $display("FAIL reset_fd_valid got %b want 0", s_fdv); end
      n_chk++; if (s_pc !== 64'h0) begin n_fail++; $display("FAIL reset_fd_pc got %h want 0", s_pc); end
      n_chk++; if (s_instr !== 32'h0) begin n_fail++; $display("FAIL reset_fd_instr got %h want 0", s_instr); end
    end
    obs_req.delete(); obs_pc.delete(); obs_instr.delete();
    step(0, 0, 0, 1, 1);
    n_chk++; if (s_req_v !== 1'b1) begin n_fail++; $display("FAIL first_req_valid got %b want 1", s_req_v); end
    n_chk++; if (s_addr !== RESET_PC) begin n_fail++; $display("FAIL first_req_addr got %h want %h", s_addr, RESET_PC); end
  endtask

  task automatic test_stream();
    int first_v = -1;
    logic [63:0] e;
    do_reset(1, 1);
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 0, 1, 1);
      if (s_fdv && first_v < 0) first_v = i;
    end
    n_chk++; if (first_v !== FIRST_LAT) begin n_fail++; $display("FAIL stream_first_valid got %0d want %0d", first_v, FIRST_LAT); end
    n_chk++; if (obs_pc.size() !== 12 - FIRST_LAT) begin n_fail++; $display("FAIL stream_pops got %0d want %0d", obs_pc.size(), 12 - FIRST_LAT); end
    n_chk++; if (obs_req.size() !== 12) begin n_fail++; $display("FAIL stream_reqs got %0d want 12", obs_req.size()); end
    for (int k = 0; k < obs_req.size(); k++) begin
      e = RESET_PC + 64'(4 * k);
      n_chk++; if (obs_req[k] !== e) begin n_fail++; $display("FAIL stream_req_addr[%0d] got %h want %h", k, obs_req[k], e); end
    end
    for (int k = 0; k < obs_pc.size(); k++) begin
      e = RESET_PC + 64'(4 * k);
      n_chk++; if (obs_pc[k] !== e) begin n_fail++; $display("FAIL stream_pc[%0d] got %h want %h", k, obs_pc[k], e); end
      n_chk++; if (obs_instr[k] !== f(e)) begin n_fail++; $display("FAIL stream_instr[%0d] got %h want %h", k, obs_instr[k], f(e)); end
    end
  endtask

  task automatic test_backpressure();
    do_reset(1, 1);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 0);
    n_chk++; if (obs_req.size() !== DEPTH) begin n_fail++; $display("FAIL bp_req_count got %0d want %0d", obs_req.size(), DEPTH); end
    n_chk++; if (s_req_v !== 1'b0) begin n_fail++; $display("FAIL bp_req_stall got %b want 0", s_req_v); end
    n_chk++; if (s_fdv !== 1'b1) begin n_fail++; $display("FAIL bp_fd_valid got %b want 1", s_fdv); end
    step(0, 0, 0, 1, 1);
    n_chk++; if (obs_pc.size() !== 1) begin n_fail++; $display("FAIL bp_one_pop got %0d want 1", obs_pc.size()); end
    else begin
      n_chk++; if (obs_pc[0] !== RESET_PC) begin n_fail++; $display("FAIL bp_pop_pc got %h want %h", obs_pc[0], RESET_PC); end
    end
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 0);
    n_chk++; if (obs_req.size() !== DEPTH + 1) begin n_fail++; $display("FAIL bp_one_more_req got %0d want %0d", obs_req.size(), DEPTH + 1); end
    else begin
      n_chk++; if (obs_req[DEPTH] !== RESET_PC + 64'h10) begin n_fail++; $display("FAIL bp_new_req_addr got %h want %h", obs_req[DEPTH], RESET_PC + 64'h10); end
    end
    n_chk++; if (s_req_v !== 1'b0) begin n_fail++; $display("FAIL bp_req_stall2 got %b want 0", s_req_v); end
  endtask

  task automatic test_branch();
    logic [63:0] e;
    do_reset(3, 3);
    for (int i = 0; i < 20; i++) begin
      step(0, i == 2, 64'h1002, 1, 1);
      if (i == 2) begin
        n_chk++; if (s_req_v !== 1'b0 || s_fdv !== 1'b0) begin n_fail++; $display("FAIL br_force_low got req=%b fd=%b want 0 0", s_req_v, s_fdv); end
      end
      if (i == 3) begin
        n_chk++; if (s_req_v !== 1'b1 || s_addr !== 64'h1000) begin n_fail++; $display("FAIL br_first_req got v=%b addr=%h want 1 1000", s_req_v, s_addr); end
      end
    end
    n_chk++; if (obs_pc.size() < 8) begin n_fail++; $display("FAIL br_pop_count got %0d want >=8", obs_pc.size()); end
    for (int k = 0; k < obs_pc.size(); k++) begin
      e = 64'h1000 + 64'(4 * k);
      n_chk++; if (obs_pc[k] !== e || obs_instr[k] !== f(e)) begin n_fail++; $display("FAIL br_pc[%0d] got %h/%h want %h/%h", k, obs_pc[k], obs_instr[k], e, f(e)); end
    end
  endtask

  task automatic test_wrap();
    do_reset(1, 1);
    step(0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 1);
    n_chk++; if (obs_req.size() < 3) begin n_fail++; $display("FAIL wrap_req_count got %0d want >=3", obs_req.size()); end
    else begin
      n_chk++; if (obs_req[0] !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_fail++; $display("FAIL wrap_req0 got %h want fffffffffffffffc", obs_req[0]); end
      n_chk++; if (obs_req[1] !== 64'h0) begin n_fail++; $display("FAIL wrap_req1 got %h want 0", obs_req[1]); end
      n_chk++; if (obs_req[2] !== 64'h4) begin n_fail++; $display("FAIL wrap_req2 got %h want 4", obs_req[2]); end
    end
    n_chk++; if (obs_pc.size() < 2) begin n_fail++; $display("FAIL wrap_pop_count got %0d want >=2", obs_pc.size()); end
    else begin
      n_chk++; if (obs_pc[0] !== 64'hFFFF_FFFF_FFFF_FFFC || obs_pc[1] !== 64'h0) begin n_fail++; $display("FAIL wrap_pcs got %h %h want fffffffffffffffc 0", obs_pc[0], obs_pc[1]); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset(1, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0);
    n_chk++; if (s_fdv !== 1'b1) begin n_fail++; $display("FAIL rmid_filled got %b want 1", s_fdv); end
    step(1, 0, 0, 1, 1);
    obs_req.delete(); obs_pc.delete(); obs_instr.delete();
    step(0, 0, 0, 1, 1);
    n_chk++; if (s_fdv !== 1'b0) begin n_fail++; $display("FAIL rmid_fd_valid got %b want 0", s_fdv); end
    n_chk++; if (s_addr !== RESET_PC) begin n_fail++; $display("FAIL rmid_addr got %h want %h", s_addr, RESET_PC); end
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 1);
    n_chk++; if (obs_pc.size() < 1 || obs_pc[0] !== RESET_PC) begin n_fail++; $display("FAIL rmid_first_pc got n=%0d want pc %h", obs_pc.size(), RESET_PC); end
  endtask

  task automatic test_branch_rsp_pop();
    do_reset(2, 2);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
    n_chk++; if (mq.size() < 1 || mq[0].due !== cyc) begin n_fail++; $display("FAIL brp_setup got pending=%0d want response due now", mq.size()); end
    step(0, 1, 64'h2000, 1, 1);   // response + pop attempt + branch together
    n_chk++; if (s_fdv !== 1'b0 || s_req_v !== 1'b0) begin n_fail++; $display("FAIL brp_force_low got fd=%b req=%b want 0 0", s_fdv, s_req_v); end
    step(0, 0, 0, 1, 1);
    n_chk++; if (s_fdv !== 1'b0) begin n_fail++; $display("FAIL brp_empty1 got %b want 0", s_fdv); end
    step(0, 0, 0, 1, 1);
    n_chk++; if (s_fdv !== 1'b0) begin n_fail++; $display("FAIL brp_empty2 got %b want 0", s_fdv); end
    n_chk++; if (obs_pc.size() !== 0) begin n_fail++; $display("FAIL brp_no_pops got %0d want 0", obs_pc.size()); end
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 1);
    n_chk++; if (obs_pc.size() < 1 || obs_pc[0] !== 64'h2000) begin n_fail++; $display("FAIL brp_first_pc got n=%0d want pc 2000", obs_pc.size()); end
  endtask

  task automatic test_random();
    logic [63:0] exp_pc, exp_req, tgt, g;
    logic [31:0] gi;
    bit br;
    int pops = 0;
    do_reset(1, 4);
    exp_pc = RESET_PC; exp_req = RESET_PC;
    for (int i = 0; i < 800; i++) begin
      br  = ($urandom_range(39, 0) == 0);
      tgt = {$urandom, $urandom};
      step(0, br, tgt, $urandom_range(3, 0) != 0, $urandom_range(2, 0) != 0);
      while (obs_req.size() > 0) begin
        g = obs_req.pop_front();
        n_chk++; if (g !== exp_req) begin n_fail++; $display("FAIL rand_req cyc %0d got %h want %h", i, g, exp_req); end
        exp_req = exp_req + 64'h4;
      end
      while (obs_pc.size() > 0) begin
        g = obs_pc.pop_front(); gi = obs_instr.pop_front();
        n_chk++; if (g !== exp_pc || gi !== f(exp_pc)) begin n_fail++; $display("FAIL rand_pop cyc %0d got %h/%h want %h/%h", i, g, gi, exp_pc, f(exp_pc)); end
        exp_pc = exp_pc + 64'h4;
        pops++;
      end
      if (br) begin
        n_chk++; if (s_fdv !== 1'b0 || s_req_v !== 1'b0) begin n_fail++; $display("FAIL rand_br_low cyc %0d got fd=%b req=%b", i, s_fdv, s_req_v); end
        exp_pc  = {tgt[63:2], 2'b00};
        exp_req = {tgt[63:2], 2'b00};
      end
    end
    n_chk++; if (pops < 150) begin n_fail++; $display("FAIL rand_progress got %0d pops want >=150", pops); end
  endtask

  initial begin
    reset_i = 1'b1; branchtaken_i = 1'b0; branch_target_i = '0;
    imem_req_ready_i = 1'b0; imem_rsp_valid_i = 1'b0; imem_rsp_data_i = '0;
    fd_ready_i = 1'b0;
    @(posedge clk_i); #1;
    test_reset();
    test_stream();
    test_backpressure();
    test_branch();
    test_wrap();
    test_reset_mid();
    test_branch_rsp_pop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
